// File: rtl/dds_voice.sv
// -----------------------------------------------------------------------------
// dds_voice
//   Single-voice direct digital synthesis oscillator. A sample-rate divider
//   issues one tick every SAMPLE_DIV clocks. On each tick the 32-bit phase
//   accumulator advances by freq_word, and amplitude and waveform select are
//   captured. A three-stage pipeline then does the following:
//     1. shape the waveform from the phase
//     2. scale it by the amplitude
//     3. present the result on a valid/ready output register
//   The output register flags an overrun when an unaccepted sample is
//   overwritten.
//
// Parameters
//   SAMPLE_DIV    clk_clk cycles per output sample (4..65535)
//
// Ports
//   clk_clk       in   1   clock, all state on rising edge
//   reset_reset_n in   1   asynchronous active-low reset
//   freq_word     in  32   phase increment per sample
//   amp           in  16   unsigned amplitude
//   wave_sel      in   2   00 saw, 01 square, 10 triangle, 11 mute
//   enable        in   1   sample generation enable
//   sample_ready  in   1   downstream accepts the current sample
//   clear_overrun in   1   clears the sticky overrun flag
//   sample_data   out 16   signed two's-complement sample
//   sample_valid  out  1   sample_data holds an unaccepted sample
//   overrun       out  1   sticky: an unaccepted sample was overwritten
// -----------------------------------------------------------------------------
module dds_voice #(
    parameter int unsigned SAMPLE_DIV = 1042
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] freq_word,
    input  logic [15:0] amp,
    input  logic [1:0]  wave_sel,
    input  logic        enable,
    input  logic        sample_ready,
    input  logic        clear_overrun,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic        overrun
);

    localparam logic [15:0] TICK_LAST = 16'(SAMPLE_DIV - 1);

    localparam logic [1:0] WAVE_SAW    = 2'b00;
    localparam logic [1:0] WAVE_SQUARE = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;

    // ---------------------------------------------------------------------
    // Sample-rate divider
    // ---------------------------------------------------------------------
    logic [15:0] r_tick_cnt;
    logic        w_tick;

    assign w_tick = enable && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_tick_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Phase accumulator and per-sample shadow registers
    // ---------------------------------------------------------------------
    logic [31:0] r_phase;
    logic [15:0] r_amp_sh;
    logic [1:0]  r_wave_sh;
    logic        r_s1_vld;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_phase   <= '0;
            r_amp_sh  <= '0;
            r_wave_sh <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_vld <= w_tick;
            if (w_tick) begin
                r_phase   <= r_phase + freq_word;
                r_amp_sh  <= amp;
                r_wave_sh <= wave_sel;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: waveform shaping from the already-advanced phase
    // ---------------------------------------------------------------------
    logic [14:0] w_tri;
    logic [15:0] w_wave;
    logic [15:0] r_wave;
    logic        r_s2_vld;

    always_comb begin
        // Fold the upper half of the cycle back down to form a triangle.
        w_tri  = r_phase[31] ? ~r_phase[30:16] : r_phase[30:16];
        w_wave = '0;
        case (r_wave_sh)
            WAVE_SAW:    w_wave = r_phase[31:16] ^ 16'h8000;
            WAVE_SQUARE: w_wave = r_phase[31] ? 16'h8001 : 16'h7FFF;
            WAVE_TRI:    w_wave = {w_tri, 1'b0} ^ 16'h8000;
            default:     w_wave = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wave   <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_wave <= w_wave;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: amplitude scaling
    //   signed wave * unsigned amp, keep bits [31:16] (floor divide by 2^16).
    //   The magnitude never exceeds 16 signed bits, so no saturation is needed.
    // ---------------------------------------------------------------------
    logic [32:0] w_wave_ext;
    logic [32:0] w_amp_ext;
    logic [32:0] w_prod;
    logic        w_unused_prod;
    logic [15:0] r_result;
    logic        r_s3_vld;

    assign w_wave_ext    = {{17{r_wave[15]}}, r_wave};
    assign w_amp_ext     = {17'd0, r_amp_sh};
    assign w_prod        = 33'($signed(w_wave_ext) * $signed(w_amp_ext));
    assign w_unused_prod = ^{w_prod[32], w_prod[15:0]};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_result <= '0;
            r_s3_vld <= 1'b0;
        end else begin
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_result <= w_prod[31:16];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 3: output register with valid/ready handshake and overrun
    // ---------------------------------------------------------------------
    logic [15:0] r_sample_data;
    logic        r_sample_valid;
    logic        r_overrun;
    logic        w_xfer;
    logic        w_ovr_set;

    assign w_xfer    = r_sample_valid && sample_ready;
    // Overwriting a held sample that is not leaving this cycle loses it.
    assign w_ovr_set = r_s3_vld && r_sample_valid && !sample_ready;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
        end else if (r_s3_vld) begin
            r_sample_data  <= r_result;
            r_sample_valid <= 1'b1;
        end else if (w_xfer) begin
            r_sample_valid <= 1'b0;
        end
    end

    // A set event takes priority over a simultaneous clear request.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_dds_voice.sv
module tb_dds_voice;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [31:0] freq_word;
    logic [15:0] amp;
    logic [1:0]  wave_sel;
    logic        enable;
    logic        sample_ready;
    logic        clear_overrun;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int kcur   = 0;

    dds_voice #(.SAMPLE_DIV(8)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .freq_word     (freq_word),
        .amp           (amp),
        .wave_sel      (wave_sel),
        .enable        (enable),
        .sample_ready  (sample_ready),
        .clear_overrun (clear_overrun),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .overrun       (overrun)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following rising edge k after reset release.
    task automatic at_k(input int k);
        while (kcur < k) begin
            @(negedge clk_clk);
            kcur++;
        end
    endtask

    // Reset for two cycles, release on a negedge; that negedge is k=0.
    task automatic do_reset();
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        kcur = 0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        freq_word     = 32'h1000_0000;
        amp           = 16'hFFFF;
        wave_sel      = 2'b00;
        enable        = 1'b1;
        sample_ready  = 1'b1;
        clear_overrun = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk_clk);
        chk("rst_data",  {16'd0, sample_data}, 32'h0000);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_ovr",   {31'd0, overrun}, 32'd0);

        // ---------------- saw ramp, ready=1 ----------------
        // Tick edges at k=8,16,24; valid 3 edges later. Saw p^8000 scaled by
        // 0xFFFF floors back to p^8000 for multiples of 0x1000.
        do_reset();
        at_k(10); chk("saw_pre_valid", {31'd0, sample_valid}, 32'd0);
        at_k(11); chk("saw_valid1", {31'd0, sample_valid}, 32'd1);
                  chk("saw_s1", {16'd0, sample_data}, 32'h9000);
        at_k(12); chk("saw_xfer_clr", {31'd0, sample_valid}, 32'd0);
        at_k(18); chk("saw_gap", {31'd0, sample_valid}, 32'd0);
        at_k(19); chk("saw_s2", {16'd0, sample_data}, 32'hA000);
                  chk("saw_valid2", {31'd0, sample_valid}, 32'd1);
        at_k(27); chk("saw_s3", {16'd0, sample_data}, 32'hB000);

        // ---------------- square, phase wraps ----------------
        // 0x8001*0x8000 = -16383.5 -> -16384 = C000; 0x7FFF*0x8000 -> 3FFF.
        freq_word = 32'h8000_0000; wave_sel = 2'b01; amp = 16'h8000;
        do_reset();
        at_k(11); chk("sq_s1", {16'd0, sample_data}, 32'hC000);
        at_k(19); chk("sq_s2", {16'd0, sample_data}, 32'h3FFF);
        at_k(27); chk("sq_s3", {16'd0, sample_data}, 32'hC000);

        // ---------------- backpressure / overrun ----------------
        freq_word = 32'h1000_0000; wave_sel = 2'b00; amp = 16'hFFFF;
        sample_ready = 1'b0;
        do_reset();
        at_k(11); chk("bp_s1", {16'd0, sample_data}, 32'h9000);
                  chk("bp_ovr0", {31'd0, overrun}, 32'd0);
        at_k(18); chk("bp_hold_data", {16'd0, sample_data}, 32'h9000);
                  chk("bp_hold_valid", {31'd0, sample_valid}, 32'd1);
        at_k(19); chk("bp_s2", {16'd0, sample_data}, 32'hA000);
                  chk("bp_valid", {31'd0, sample_valid}, 32'd1);
                  chk("bp_ovr1", {31'd0, overrun}, 32'd1);
        at_k(20); clear_overrun = 1'b1;
        at_k(21); clear_overrun = 1'b0;
                  chk("bp_ovr_clr", {31'd0, overrun}, 32'd0);
        // Clear coincident with a new overrun: the set must win.
        at_k(26); clear_overrun = 1'b1;
        at_k(27); clear_overrun = 1'b0;
                  chk("bp_set_wins", {31'd0, overrun}, 32'd1);
                  chk("bp_s3", {16'd0, sample_data}, 32'hB000);
                  sample_ready = 1'b1;
        at_k(28); chk("bp_one_xfer", {31'd0, sample_valid}, 32'd0);
                  chk("bp_ovr_sticky", {31'd0, overrun}, 32'd1);
                  clear_overrun = 1'b1; sample_ready = 1'b0;
        at_k(29); clear_overrun = 1'b0;
                  chk("bp_ovr_clr2", {31'd0, overrun}, 32'd0);
        // Load coincident with a transfer: valid stays, no overrun.
        at_k(35); chk("bp_s4", {16'd0, sample_data}, 32'hC000);
        at_k(42); sample_ready = 1'b1;
        at_k(43); chk("bp_ld_xfer_data", {16'd0, sample_data}, 32'hD000);
                  chk("bp_ld_xfer_valid", {31'd0, sample_valid}, 32'd1);
                  chk("bp_ld_xfer_ovr", {31'd0, overrun}, 32'd0);
        at_k(44); chk("bp_final_xfer", {31'd0, sample_valid}, 32'd0);

        // ---------------- triangle ----------------
        // Waves 0000, 7FFE, FFFE, 8000 scaled by 0xFFFF with floor:
        //   0 -> 0000; 32766*65535>>16 = 7FFD; -2*65535>>16 = FFFE;
        //   -32768*65535>>16 = 8000.
        freq_word = 32'h4000_0000; wave_sel = 2'b10; amp = 16'hFFFF;
        do_reset();
        at_k(11); chk("tri_s1", {16'd0, sample_data}, 32'h0000);
                  chk("tri_v1", {31'd0, sample_valid}, 32'd1);
        at_k(19); chk("tri_s2", {16'd0, sample_data}, 32'h7FFD);
        at_k(27); chk("tri_s3", {16'd0, sample_data}, 32'hFFFE);
        at_k(35); chk("tri_s4", {16'd0, sample_data}, 32'h8000);
        at_k(43); chk("tri_s5", {16'd0, sample_data}, 32'h0000);

        // ---------------- mute, amp=0, mid-period changes, enable ----------------
        freq_word = 32'h1000_0000; wave_sel = 2'b11; amp = 16'hFFFF;
        do_reset();
        at_k(11); chk("mute_valid", {31'd0, sample_valid}, 32'd1);
                  chk("mute_data", {16'd0, sample_data}, 32'h0000);
        at_k(12); wave_sel = 2'b00; amp = 16'h0000;
        // Changed after the k=16 tick: must not affect that sample.
        at_k(17); amp = 16'hFFFF; freq_word = 32'h2000_0000;
        at_k(19); chk("amp0_valid", {31'd0, sample_valid}, 32'd1);
                  chk("amp0_data", {16'd0, sample_data}, 32'h0000);
        // Phase 0x2000_0000 + 0x2000_0000 = 0x4000_0000 -> C000.
        at_k(27); chk("fchg_s1", {16'd0, sample_data}, 32'hC000);
        at_k(35); chk("fchg_s2", {16'd0, sample_data}, 32'hE000);
        at_k(36); enable = 1'b0; freq_word = 32'h1000_0000;
        at_k(43); chk("dis_no_tick", {31'd0, sample_valid}, 32'd0);
        at_k(44); enable = 1'b1;
        at_k(54); chk("en_pre_valid", {31'd0, sample_valid}, 32'd0);
        at_k(55); chk("en_valid", {31'd0, sample_valid}, 32'd1);
                  chk("en_data", {16'd0, sample_data}, 32'hF000);

        // ---------------- async reset while valid ----------------
        freq_word = 32'h1000_0000; wave_sel = 2'b00; amp = 16'hFFFF;
        sample_ready = 1'b0;
        do_reset();
        at_k(19); chk("ar_pre_valid", {31'd0, sample_valid}, 32'd1);
                  chk("ar_pre_ovr", {31'd0, overrun}, 32'd1);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("ar_data", {16'd0, sample_data}, 32'h0000);
        chk("ar_valid", {31'd0, sample_valid}, 32'd0);
        chk("ar_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk_clk);
        sample_ready = 1'b1;
        reset_reset_n = 1'b1;
        kcur = 0;
        at_k(10); chk("ar_post_pre", {31'd0, sample_valid}, 32'd0);
        at_k(11); chk("ar_post_valid", {31'd0, sample_valid}, 32'd1);
                  chk("ar_post_data", {16'd0, sample_data}, 32'h9000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
